// File: rtl/z_result_buffer.sv
// z_result_buffer
//   Small result FIFO that sits between the ALU datapath and the internal
//   bus, so the control unit can stall the bus without losing a result.
//   Each entry holds a {hi,lo} result plus zero/negative flags that are
//   computed when the entry is pushed.
//
// Ports
//   clk        rising-edge clock
//   clr        synchronous active-low reset
//   in_valid   ALU result present on in_hi/in_lo
//   in_ready   space available (count < DEPTH)
//   in_hi      upper result half
//   in_lo      lower result half
//   out_valid  head entry present (count != 0)
//   out_ready  consumer pops the head entry
//   ZHighout   drive head.hi onto bus_out (wins over ZLowout)
//   ZLowout    drive head.lo onto bus_out
//   bus_out    selected head half, otherwise 0
//   out_zero   head.hi == 0 and head.lo == 0 (0 when empty)
//   out_neg    head.lo MSB (0 when empty)
//   count      occupancy, 0..DEPTH
//   ovf_err    sticky: push attempted while full; cleared by reset only
module z_result_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 2
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_hi,
   input  logic [DATA_W-1:0] in_lo,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              ZHighout,
   input  logic              ZLowout,
   output logic [DATA_W-1:0] bus_out,
   output logic              out_zero,
   output logic              out_neg,
   output logic [CNT_W-1:0]  count,
   output logic              ovf_err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Data storage carries no reset; only pointers/count/flag do.
   logic [DATA_W-1:0] hi_mem [DEPTH];
   logic [DATA_W-1:0] lo_mem [DEPTH];
   logic              zero_mem [DEPTH];
   logic              neg_mem  [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             push, pop;

   // in_ready depends on registered count only, so a pop in the same cycle
   // never opens room for a push while full.
   assign in_ready  = (count_q < FULL_CNT);
   assign out_valid = (count_q != '0);
   assign count     = count_q;
   assign ovf_err   = ovf_q;

   assign push = in_valid & in_ready;
   assign pop  = out_ready & out_valid;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      if (in_valid && !in_ready) ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (clr && push) begin
         hi_mem[wr_ptr_q]   <= in_hi;
         lo_mem[wr_ptr_q]   <= in_lo;
         zero_mem[wr_ptr_q] <= (in_hi == '0) && (in_lo == '0);
         neg_mem[wr_ptr_q]  <= in_lo[DATA_W-1];
      end
   end

   always_comb begin
      bus_out = '0;
      if (out_valid) begin
         if (ZHighout)     bus_out = hi_mem[rd_ptr_q];
         else if (ZLowout) bus_out = lo_mem[rd_ptr_q];
      end
   end

   assign out_zero = out_valid & zero_mem[rd_ptr_q];
   assign out_neg  = out_valid & neg_mem[rd_ptr_q];

endmodule

// File: tb/tb_z_result_buffer.sv
module tb_z_result_buffer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 2;

  logic              clk, clr, in_valid, in_ready, out_valid, out_ready;
  logic              ZHighout, ZLowout, out_zero, out_neg, ovf_err;
  logic [DATA_W-1:0] in_hi, in_lo, bus_out;
  logic [CNT_W-1:0]  count;

  z_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_hi(in_hi), .in_lo(in_lo), .out_valid(out_valid), .out_ready(out_ready),
    .ZHighout(ZHighout), .ZLowout(ZLowout), .bus_out(bus_out),
    .out_zero(out_zero), .out_neg(out_neg), .count(count), .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: a queue of {hi,lo} results and a sticky overflow bit.
  logic [63:0] q[$];
  bit          m_ovf;
  bit          known = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [63:0] head;
    logic [31:0] exp_bus;
    bit          ne;
    ne = (q.size() != 0);
    head = ne ? q[0] : 64'h0;
    exp_bus = 32'h0;
    if (ne) exp_bus = ZHighout ? head[63:32] : (ZLowout ? head[31:0] : 32'h0);
    check("in_ready",  64'(in_ready),  64'(q.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(ne));
    check("count",     64'(count),     64'(q.size()));
    check("ovf_err",   64'(ovf_err),   64'(m_ovf));
    check("bus_out",   64'(bus_out),   64'(exp_bus));
    check("out_zero",  64'(out_zero),  64'(ne && head == 64'h0));
    check("out_neg",   64'(out_neg),   64'(ne && head[31]));
  endtask

  // One clock: drive at negedge, check outputs, then apply the model at posedge.
  task automatic cyc(input bit rn, input bit v, input logic [31:0] hi, input logic [31:0] lo,
                     input bit ordy, input bit zh, input bit zl);
    bit full;
    @(negedge clk);
    clr = rn; in_valid = v; in_hi = hi; in_lo = lo;
    out_ready = ordy; ZHighout = zh; ZLowout = zl;
    #1;
    if (known) check_outputs();
    @(posedge clk);
    if (!rn) begin
      q.delete(); m_ovf = 0; known = 1;
    end else if (known) begin
      full = (q.size() >= DEPTH);
      if (v && full) m_ovf = 1;
      if (ordy && q.size() > 0) void'(q.pop_front());
      if (v && !full) q.push_back({hi, lo});
    end
  endtask

  task automatic idle(input bit zh, input bit zl);
    cyc(1, 0, 32'h0, 32'h0, 0, zh, zl);
  endtask

  initial begin
    clr = 0; in_valid = 0; in_hi = 0; in_lo = 0; out_ready = 0; ZHighout = 0; ZLowout = 0;
    // reset for two cycles, then single push with negative low half
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h0, 32'h80000001, 0, 0, 0);
    idle(0, 1);
    check("single_lo", 64'(bus_out), 64'h80000001);
    check("single_neg", 64'(out_neg), 64'h1);
    idle(1, 0);
    check("single_hi", 64'(bus_out), 64'h0);
    cyc(1, 0, 0, 0, 1, 0, 1);
    // fill and overflow
    cyc(1, 1, 32'h0, 32'h11111111, 0, 0, 1);
    cyc(1, 1, 32'h0, 32'h22222222, 0, 0, 1);
    cyc(1, 1, 32'h0, 32'h33333333, 0, 0, 1);
    idle(0, 1);
    check("fill_ovf", 64'(ovf_err), 64'h1);
    check("fill_head", 64'(bus_out), 64'h11111111);
    cyc(1, 0, 0, 0, 1, 0, 1);
    cyc(1, 0, 0, 0, 1, 0, 1);
    idle(0, 1);
    // streaming at count=1 with out_ready high, pointers wrap
    cyc(1, 1, 32'hA, 32'h1000, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 1, 32'hA0 + i, 32'h2000 + i, 1, 0, 1);
    cyc(1, 0, 0, 0, 1, 1, 0);
    // full with simultaneous push and pop
    cyc(1, 1, 32'h5, 32'h55, 0, 0, 0);
    cyc(1, 1, 32'h6, 32'h66, 0, 0, 0);
    cyc(1, 1, 32'h7, 32'h77, 1, 1, 0);
    idle(1, 0);
    check("full_pp_cnt", 64'(count), 64'h1);
    check("full_pp_head", 64'(bus_out), 64'h6);
    cyc(1, 0, 0, 0, 1, 0, 0);
    // zero flag, then empty bus with both selects
    cyc(1, 1, 32'h0, 32'h0, 0, 0, 0);
    idle(1, 1);
    check("zero_flag", 64'(out_zero), 64'h1);
    cyc(1, 0, 0, 0, 1, 1, 1);
    idle(1, 1);
    // reset mid-stream with push and pop asserted
    cyc(1, 1, 32'h1, 32'h1, 0, 0, 0);
    cyc(1, 1, 32'h2, 32'h2, 0, 0, 0);
    cyc(0, 1, 32'h3, 32'h3, 1, 0, 0);
    idle(0, 0);
    check("rst_cnt", 64'(count), 64'h0);
    check("rst_ovf", 64'(ovf_err), 64'h0);
    cyc(1, 1, 32'hCAFE, 32'hBEEF, 0, 0, 0);
    idle(1, 0);
    check("rst_next", 64'(bus_out), 64'hCAFE);
    cyc(1, 0, 0, 0, 1, 0, 0);
    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] h, l;
      h = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      l = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      cyc(($urandom_range(0, 39) != 0), $urandom_range(0, 1) != 0, h, l,
          $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
    end
    idle(0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
